// File: rtl/chan_scan_if.sv
// Control/status bundle between a scan controller and chan_scan_sequencer.
// The controller (master) drives start/stop and the scan configuration;
// the sequencer (slave) returns the channel index and status pulses.
interface chan_scan_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [7:0]         chan_mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic               done;
  logic               wrap;

  modport master (
    output start, stop, mode, chan_mask, dwell,
    input  sel, sel_valid, busy, done, wrap
  );

  modport slave (
    input  start, stop, mode, chan_mask, dwell,
    output sel, sel_valid, busy, done, wrap
  );
endinterface

// File: rtl/chan_scan_sequencer.sv
// Channel scan sequencer: walks the enabled bits of an 8-bit mask in
// ascending order, holding each channel index for dwell+1 cycles, either
// once (done pulse at the end) or continuously (wrap pulse on each return
// to the lowest enabled channel). All outputs are registered.
module chan_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  chan_scan_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Configuration captured at start; inputs are ignored while busy.
  logic [7:0]         r_mask;
  logic [7:0]         w_mask_next;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_next;
  logic               r_mode;
  logic               w_mode_next;

  // Dwell counter compares before incrementing, so it never exceeds r_dwell.
  logic [DWELL_W-1:0] r_count;
  logic [DWELL_W-1:0] w_count_next;

  logic [2:0]         r_sel;
  logic [2:0]         w_sel_next;
  logic               r_sel_valid;
  logic               w_sel_valid_next;
  logic               r_busy;
  logic               w_busy_next;
  logic               r_done;
  logic               w_done_next;
  logic               r_wrap;
  logic               w_wrap_next;

  logic [7:0]         w_above;
  logic               w_has_higher;
  logic [2:0]         w_higher_idx;
  logic [2:0]         w_start_low;
  logic [2:0]         w_wrap_low;
  logic               w_count_hit;
  logic               w_start_ok;
  logic               w_start_empty;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [2:0] f_lowest(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Latched mask bits strictly above the current channel.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
      assign w_above[gi] = r_mask[gi] & (3'(gi) > r_sel);
    end
  endgenerate

  assign w_has_higher  = |w_above;
  assign w_higher_idx  = f_lowest(w_above);
  assign w_start_low   = f_lowest(bus.chan_mask);
  assign w_wrap_low    = f_lowest(r_mask);
  assign w_count_hit   = (r_count == r_dwell);
  assign w_start_ok    = bus.start && !bus.stop && (bus.chan_mask != 8'h00);
  assign w_start_empty = bus.start && !bus.stop && (bus.chan_mask == 8'h00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decision: stop always returns to IDLE; a single sweep
  // ends when the last enabled channel finishes its dwell.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_DWELL;
      end
      S_DWELL: begin
        if (bus.stop)
          w_state_next = S_IDLE;
        else if (w_count_hit && !w_has_higher && !r_mode)
          w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, counter and latched configuration.
  always_comb begin
    w_mask_next      = r_mask;
    w_dwell_next     = r_dwell;
    w_mode_next      = r_mode;
    w_count_next     = r_count;
    w_sel_next       = r_sel;
    w_sel_valid_next = r_sel_valid;
    w_busy_next      = r_busy;
    w_done_next      = 1'b0;
    w_wrap_next      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_sel_valid_next = 1'b0;
        w_busy_next      = 1'b0;
        if (w_start_ok) begin
          w_mask_next      = bus.chan_mask;
          w_dwell_next     = bus.dwell;
          w_mode_next      = bus.mode;
          w_count_next     = '0;
          w_sel_next       = w_start_low;
          w_sel_valid_next = 1'b1;
          w_busy_next      = 1'b1;
        end else if (w_start_empty) begin
          // Nothing to scan: report completion without ever going valid.
          w_done_next = 1'b1;
        end
      end
      S_DWELL: begin
        if (bus.stop) begin
          w_sel_valid_next = 1'b0;
          w_busy_next      = 1'b0;
        end else if (w_count_hit) begin
          w_count_next = '0;
          if (w_has_higher) begin
            w_sel_next = w_higher_idx;
          end else if (r_mode) begin
            w_sel_next  = w_wrap_low;
            w_wrap_next = 1'b1;
          end else begin
            w_sel_valid_next = 1'b0;
            w_busy_next      = 1'b0;
            w_done_next      = 1'b1;
          end
        end else begin
          w_count_next = r_count + 1'b1;
        end
      end
      default: begin
        w_sel_valid_next = 1'b0;
        w_busy_next      = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= '0;
      r_dwell     <= '0;
      r_mode      <= 1'b0;
      r_count     <= '0;
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_mask      <= w_mask_next;
      r_dwell     <= w_dwell_next;
      r_mode      <= w_mode_next;
      r_count     <= w_count_next;
      r_sel       <= w_sel_next;
      r_sel_valid <= w_sel_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_wrap      <= w_wrap_next;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.sel_valid = r_sel_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_chan_scan_sequencer.sv
// Directed testbench for chan_scan_sequencer. Inputs change and outputs are
// sampled on the falling edge; observed outputs are packed as
// {sel[2:0], sel_valid, busy, done, wrap}.
module tb_chan_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  chan_scan_if #(.DWELL_W(8)) bus ();

  chan_scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [6:0] obs;
  assign obs = {bus.sel, bus.sel_valid, bus.busy, bus.done, bus.wrap};

  // Advance one clock, returning at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] exp;
    exp = 7'b000_0000;
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL reset_values: got %b expected %b", obs, exp);
    end
    rst_n = 1'b1;
    tick();
    // Start a sweep and reset in the middle of channel 3.
    bus.chan_mask = 8'hFF; bus.dwell = 8'd2; bus.mode = 1'b0;
    pulse_start();
    for (int k = 1; k <= 10; k++) tick();
    exp = {3'd3, 4'b1100};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL midscan_before_reset: got %b expected %b", obs, exp);
    end
    #2 rst_n = 1'b0;
    #1;
    exp = 7'b000_0000;
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL async_reset: got %b expected %b", obs, exp);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL idle_after_reset c%0d: got %b expected %b", k, obs, exp);
      end
    end
    $display("test_reset done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  task automatic test_single_sweep();
    logic [6:0] exp;
    bus.chan_mask = 8'hFF; bus.dwell = 8'd2; bus.mode = 1'b0;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      exp = {3'(k / 3), 4'b1100};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL sweep c%0d: got %b expected %b", k, obs, exp);
      end
      tick();
    end
    exp = {3'd7, 4'b0010};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL sweep_done: got %b expected %b", obs, exp);
    end
    tick();
    exp = {3'd7, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL sweep_done_pulse_width: got %b expected %b", obs, exp);
    end
    $display("test_single_sweep done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  task automatic test_masked_continuous();
    logic [6:0] exp;
    logic [2:0] seq [3];
    seq[0] = 3'd2; seq[1] = 3'd5; seq[2] = 3'd7;
    bus.chan_mask = 8'b1010_0100; bus.dwell = 8'd0; bus.mode = 1'b1;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      exp = {seq[k % 3], 3'b110, (k >= 3 && (k % 3) == 0)};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL continuous c%0d: got %b expected %b", k, obs, exp);
      end
      tick();
    end
    // Now at cycle 9: sel=2 with wrap. Stop here.
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp = {3'd2, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL stop_continuous: got %b expected %b", obs, exp);
    end
    tick();
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL stop_no_done: got %b expected %b", obs, exp);
    end
    $display("test_masked_continuous done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  task automatic test_empty_mask();
    logic [6:0] exp;
    bus.chan_mask = 8'h00; bus.dwell = 8'd3; bus.mode = 1'b0;
    pulse_start();
    exp = {3'd2, 4'b0010};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL empty_done: got %b expected %b", obs, exp);
    end
    tick();
    exp = {3'd2, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL empty_done_width: got %b expected %b", obs, exp);
    end
    $display("test_empty_mask done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  task automatic test_latching();
    logic [6:0] exp;
    bus.chan_mask = 8'h81; bus.dwell = 8'd1; bus.mode = 1'b0;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      exp = {(k < 2) ? 3'd0 : 3'd7, 4'b1100};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL latch c%0d: got %b expected %b", k, obs, exp);
      end
      if (k == 0) begin
        bus.chan_mask = 8'hFF; bus.dwell = 8'd5; bus.mode = 1'b1; bus.start = 1'b1;
      end
      if (k == 1) bus.start = 1'b0;
      tick();
    end
    exp = {3'd7, 4'b0010};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL latch_done: got %b expected %b", obs, exp);
    end
    tick();
    // start together with stop in IDLE: no scan.
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    exp = {3'd7, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL start_stop_priority: got %b expected %b", obs, exp);
    end
    bus.start = 1'b0; bus.stop = 1'b0;
    tick();
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL start_stop_stays_idle: got %b expected %b", obs, exp);
    end
    $display("test_latching done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  task automatic test_dwell_limits();
    logic [6:0] exp;
    bus.chan_mask = 8'h01; bus.dwell = 8'hFF; bus.mode = 1'b1;
    pulse_start();
    for (int c = 0; c <= 520; c++) begin
      exp = {3'd0, 3'b110, (c > 0 && (c % 256) == 0)};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL dwell_max c%0d: got %b expected %b", c, obs, exp);
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    bus.dwell = 8'd0;
    pulse_start();
    for (int c = 0; c < 6; c++) begin
      exp = {3'd0, 3'b110, (c > 0)};
      n_checks++;
      if (obs !== exp) begin
        n_fails++;
        $display("FAIL dwell_zero c%0d: got %b expected %b", c, obs, exp);
      end
      tick();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    exp = {3'd0, 4'b0000};
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL dwell_zero_stop: got %b expected %b", obs, exp);
    end
    $display("test_dwell_limits done: checks=%0d fails=%0d", n_checks, n_fails);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
    bus.chan_mask = 8'h00; bus.dwell = 8'd0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single_sweep();
    test_masked_continuous();
    test_empty_mask();
    test_latching();
    test_dwell_limits();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chan_scan_sequencer.md
Name: chan_scan_sequencer

Overview:
- Generates the 3-bit channel index that feeds the 3-to-8 one-hot decoder stage.
- Steps through the enabled channels of an 8-bit mask in ascending order.
- Holds each channel for a programmable number of cycles, either for a single sweep or continuously.
- Provides start/stop control and busy/done/wrap status so a controller can strobe 8 loads (LEDs, mux legs, sensor enables) one at a time.

Parameters:
- DWELL_W, 8, width of the dwell register and counter. Each channel is held for dwell+1 cycles.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a scan; sampled only in IDLE
- stop  input  1  abort the scan; has priority over start
- mode  input  1  0 = single sweep, 1 = continuous; latched at start
- chan_mask  input  8  1 = channel enabled; latched at start
- dwell  input  DWELL_W  hold count per channel minus 1; latched at start
- sel  output  3  current channel index, fed to the decoder input
- sel_valid  output  1  sel is active; gate the decoder outputs with this
- busy  output  1  scan in progress
- done  output  1  one-cycle pulse when a single sweep completes
- wrap  output  1  one-cycle pulse when a continuous scan returns to its lowest channel

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: sel=0, sel_valid=0, busy=0, done=0, wrap=0. All internal registers clear and the FSM goes to IDLE.
- Output timing: all outputs are registered. done and wrap are single-cycle pulses.
- States: IDLE and DWELL.
- IDLE:
  - Outputs: sel_valid=0, busy=0, and sel holds its last value.
  - On a clock edge with start=1, stop=0 and chan_mask!=0: latch mask, dwell and mode; set sel to the lowest set bit of the mask; set sel_valid=1 and busy=1; clear the counter; go to DWELL. Latency from start to valid sel is 1 cycle.
  - start=1 with chan_mask==0: stay in IDLE and pulse done the next cycle. No sel_valid is produced.
- DWELL:
  - The counter increments every cycle.
  - When count==latched dwell, advance on the next edge and reset the counter.
  - Advance target: the next higher set bit of the latched mask, found by a priority search above sel with no gap cycle. sel_valid stays 1 across the change.
  - No higher set bit, mode=0: go to IDLE with sel_valid=0, busy=0 and done=1 for one cycle.
  - No higher set bit, mode=1: sel becomes the lowest set bit and wrap=1 for one cycle, concurrent with that new sel.
- Single-channel masks:
  - Continuous mode re-enters the same channel; wrap pulses every dwell+1 cycles.
  - Single mode finishes after one dwell.
- dwell=0: each channel lasts 1 cycle.
- dwell at maximum (2^DWELL_W-1): each channel lasts 2^DWELL_W cycles. The counter must not overflow before the compare.
- stop=1 in any state: go to IDLE on the next edge with sel_valid=0 and busy=0. No done or wrap pulse, and sel holds. stop and start together: stop wins and no scan starts.
- start while busy is ignored. Changes to chan_mask, dwell or mode while busy have no effect until the next start.
- Reset mid-scan: all outputs take their reset values immediately (asynchronously). After rst_n deasserts, the block stays in IDLE until a new start.
- Decoder interface: sel is always a legal 0..7 value. Downstream logic uses sel_valid to suppress the decoder output when idle.

Test Plan:
- Reset mid-scan: mask=8'hFF, dwell=2, mode=0; drop rst_n in the middle of channel 3 -> all outputs 0 immediately. Then raise rst_n with start=0 -> block stays idle, busy=0.
- Single sweep: mask=8'hFF, dwell=2, mode=0, pulse start -> sel holds 0,1,...,7 for 3 cycles each with sel_valid=1 for 24 cycles. done=1 on the following cycle with busy=0, and no wrap.
- Masked continuous: mask=8'b1010_0100, dwell=0, mode=1 -> sel sequence 2,5,7,2,5,7..., and wrap=1 each cycle sel returns to 2. Then assert stop -> sel_valid=0 and busy=0 next cycle, with no done.
- Empty mask: mask=8'h00, pulse start -> sel_valid stays 0, busy stays 0, done=1 for exactly one cycle.
- Latching and priority: during a scan with mask=8'h81, change mask to 8'hFF and pulse start -> sequence stays 0,7 and start is ignored. Assert start and stop together in IDLE -> no scan begins.
- Dwell limits: DWELL_W=8, dwell=8'hFF, mask=8'h01, mode=1 -> wrap pulses every 256 cycles and sel stays 0. With dwell=0, mask=8'h01, mode=1 -> wrap=1 every cycle.
